// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between instruction fetch and data load/store.
// Data has priority; a streak counter bounds instruction starvation and a watchdog aborts hung grants.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              merr
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state, nextState;
    logic [3:0] streak, nextStreak;
    logic [7:0] timer, nextTimer;
    logic       nextMerr;
    logic       dReq, access, ramErr, timeUp, iDone, dDone;

    assign dReq   = dREN | dWEN;
    assign access = (ramstate == ACCESS);
    assign ramErr = (ramstate == ERROR);
    assign timeUp = (timer == TIMER_LAST);
    assign iDone  = (state == IGNT) && iREN && access;
    assign dDone  = (state == DGNT) && dReq && access;
    assign iload  = ramload;
    assign dload  = ramload;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
            timer  <= '0;
            merr   <= 1'b0;
        end else begin
            state  <= nextState;
            streak <= nextStreak;
            timer  <= nextTimer;
            merr   <= nextMerr;
        end
    end

    always_comb begin
        nextState = state;
        nextTimer = '0;
        nextMerr  = 1'b0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        case (state)
            IDLE: begin
                if (dReq && !(iREN && streak == STREAK_MAX))
                    nextState = DGNT;
                else if (iREN)
                    nextState = IGNT;
            end
            IGNT: begin
                // enables track the live request so a withdrawn fetch never reaches RAM
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    nextState = IDLE;
                end else if (access) begin
                    iwait     = 1'b0;
                    nextState = IDLE;
                end else if (ramErr || timeUp) begin
                    nextState = IDLE;
                    nextMerr  = 1'b1;
                end else begin
                    nextTimer = (timer == 8'hFF) ? timer : timer + 8'd1;
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dReq) begin
                    nextState = IDLE;
                end else if (access) begin
                    dwait     = 1'b0;
                    nextState = IDLE;
                end else if (ramErr || timeUp) begin
                    nextState = IDLE;
                    nextMerr  = 1'b1;
                end else begin
                    nextTimer = (timer == 8'hFF) ? timer : timer + 8'd1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        nextStreak = streak;
        if (!iREN || iDone)
            nextStreak = '0;
        else if (dDone && streak != STREAK_MAX)
            nextStreak = streak + 4'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requester sequences, a small RAM model,
// and a monitor that pops expected completions/errors whenever the DUT reports one.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        iwait, dwait, ramREN, ramWEN, merr;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        forceErr = 1'b0, forceBusy = 1'b0;
    logic [31:0] mem [0:255];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          kind;     // 0 I completion, 1 D completion, 2 merr
        bit          chkData;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .merr(merr)
    );

    always #5 CLK = ~CLK;

    // RAM model: zero-latency ACCESS unless forced BUSY or ERROR
    always_comb begin
        if (!(ramREN || ramWEN)) ramstate = 2'd0;
        else if (forceErr)       ramstate = 2'd3;
        else if (forceBusy)      ramstate = 2'd1;
        else                     ramstate = 2'd2;
    end
    assign ramload = mem[ramaddr[9:2]];
    always @(posedge CLK)
        if (ramWEN && ramstate == 2'd2) mem[ramaddr[9:2]] <= ramstore;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input bit c, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.chkData = c; e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // waits (bounded) for a completion; n = negedges observed including the completion one
    task automatic waitFor(input int which, input string nm, output int n);
        bit seen = 0;
        n = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            n++;
            if ((which == 0) ? !iwait : !dwait) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no completion within 40 cycles", nm);
        end
    endtask

    always @(negedge CLK) begin
        int   kind;
        exp_t e;
        if (nRST) begin
            chk("both enables", 32'(ramREN & ramWEN), 32'd0);
            chk("both waits low", 32'(!iwait && !dwait), 32'd0);
            if (!iwait || !dwait || merr) begin
                kind = !iwait ? 0 : (!dwait ? 1 : 2);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected event: got kind %0d expected none", kind);
                end else begin
                    e = sb.pop_front();
                    chk("event kind", 32'(kind), 32'(e.kind));
                    if (e.chkData) chk("load data", (kind == 0) ? iload : dload, e.data);
                end
            end
        end
    end

    initial begin
        int n, g, dcnt;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[16] = 32'hDEADBEEF;   // 0x40
        mem[17] = 32'h11111111;   // 0x44
        mem[18] = 32'h22222222;   // 0x48

        // reset held with a pending fetch
        iREN = 1'b1; iaddr = 32'h40;
        push(0, 1, 32'hDEADBEEF);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset iwait", 32'(iwait), 32'd1);
        chk("reset dwait", 32'(dwait), 32'd1);
        chk("reset ramREN", 32'(ramREN), 32'd0);
        chk("reset ramWEN", 32'(ramWEN), 32'd0);
        chk("reset merr", 32'(merr), 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;
        @(negedge CLK);
        chk("idle after release ramREN", 32'(ramREN), 32'd0);
        tick();
        @(negedge CLK);
        chk("fetch ramREN", 32'(ramREN), 32'd1);
        chk("fetch ramaddr", ramaddr, 32'h40);
        chk("fetch iwait low", 32'(iwait), 32'd0);
        tick(); iREN = 1'b0;
        @(negedge CLK);
        chk("iwait one cycle", 32'(iwait), 32'd1);

        // fetch latency from IDLE
        tick();
        iREN = 1'b1; iaddr = 32'h44;
        push(0, 1, 32'h11111111);
        waitFor(0, "fetch 0x44", n);
        chk("fetch latency", 32'(n), 32'd2);
        tick(); iREN = 1'b0;

        // simultaneous write and fetch: D first
        iREN = 1'b1; iaddr = 32'h40;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        push(1, 0, 32'h0);
        push(0, 1, 32'hDEADBEEF);
        tick();
        @(negedge CLK);
        chk("write ramWEN", 32'(ramWEN), 32'd1);
        chk("write ramREN", 32'(ramREN), 32'd0);
        chk("write ramaddr", ramaddr, 32'h80);
        chk("write ramstore", ramstore, 32'h1234);
        chk("write dwait low", 32'(dwait), 32'd0);
        chk("fetch stalled", 32'(iwait), 32'd1);
        tick(); dWEN = 1'b0;
        waitFor(0, "fetch after write", n);
        chk("fetch after write latency", 32'(n), 32'd2);
        tick(); iREN = 1'b0;

        // read back the written word
        dREN = 1'b1; daddr = 32'h80;
        push(1, 1, 32'h1234);
        waitFor(1, "readback", n);
        chk("readback latency", 32'(n), 32'd2);
        tick(); dREN = 1'b0;

        // starvation: 4 D grants then I, then D wins again once streak clears
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; daddr = 32'h48;
        for (int k = 0; k < 4; k++) push(1, 1, 32'h22222222);
        push(0, 1, 32'h11111111);
        push(1, 1, 32'h22222222);
        push(0, 1, 32'h11111111);
        dcnt = 0;
        begin
            bit seen = 0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge CLK);
                if (!dwait) dcnt++;
                if (!iwait) seen = 1;
            end
            if (!seen) begin
                vectors++; miscompares++;
                $display("FAIL starvation: no I grant within 40 cycles");
            end
        end
        chk("D grants before I", 32'(dcnt), 32'd4);
        tick();
        waitFor(1, "D after I", n);
        chk("D wins after streak cleared", 32'(n), 32'd2);
        tick(); dREN = 1'b0;
        waitFor(0, "final I", n);
        tick(); iREN = 1'b0;

        // RAM error during DGNT
        forceErr = 1'b1;
        dREN = 1'b1; daddr = 32'h48;
        push(2, 0, 32'h0);
        tick();
        @(negedge CLK);
        chk("error ramREN", 32'(ramREN), 32'd1);
        chk("error dwait held", 32'(dwait), 32'd1);
        tick(); dREN = 1'b0;
        @(negedge CLK);
        chk("error merr", 32'(merr), 32'd1);
        chk("error back to idle", 32'(ramREN), 32'd0);
        tick();
        @(negedge CLK);
        chk("error merr one cycle", 32'(merr), 32'd0);
        forceErr = 1'b0;

        // watchdog timeout with RAM stuck BUSY
        forceBusy = 1'b1;
        iREN = 1'b1; iaddr = 32'h40;
        push(2, 0, 32'h0);
        g = 0;
        begin
            bit done = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge CLK);
                if (ramREN) g++;
                else if (g > 0) done = 1;
            end
        end
        iREN = 1'b0;
        chk("grant cycles before timeout", 32'(g), 32'd8);
        chk("timeout merr", 32'(merr), 32'd1);
        tick();
        @(negedge CLK);
        chk("timeout merr one cycle", 32'(merr), 32'd0);

        // requester withdraws while BUSY
        tick();
        dREN = 1'b1; daddr = 32'h48;
        tick();
        @(negedge CLK);
        chk("drop ramREN before", 32'(ramREN), 32'd1);
        tick(); dREN = 1'b0;
        @(negedge CLK);
        chk("drop ramREN same cycle", 32'(ramREN), 32'd0);
        chk("drop dwait", 32'(dwait), 32'd1);
        tick();
        @(negedge CLK);
        chk("drop no merr", 32'(merr), 32'd0);

        // reset mid-DGNT
        tick();
        dWEN = 1'b1; daddr = 32'h48; dstore = 32'h55;
        tick();
        @(negedge CLK);
        chk("pre-reset ramWEN", 32'(ramWEN), 32'd1);
        chk("pre-reset ramstore", ramstore, 32'h55);
        nRST = 1'b0;
        tick();
        @(negedge CLK);
        chk("mid reset ramREN", 32'(ramREN), 32'd0);
        chk("mid reset ramWEN", 32'(ramWEN), 32'd0);
        chk("mid reset ramaddr", ramaddr, 32'h0);
        chk("mid reset ramstore", ramstore, 32'h0);
        chk("mid reset iwait", 32'(iwait), 32'd1);
        chk("mid reset dwait", 32'(dwait), 32'd1);
        chk("mid reset merr", 32'(merr), 32'd0);
        dWEN = 1'b0; forceBusy = 1'b0;
        tick(); nRST = 1'b1;

        // recovery fetch
        iREN = 1'b1; iaddr = 32'h40;
        push(0, 1, 32'hDEADBEEF);
        waitFor(0, "recovery fetch", n);
        chk("recovery latency", 32'(n), 32'd2);
        tick(); iREN = 1'b0;

        repeat (3) tick();
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared RAM port between the instruction fetch path and the data load/store path.
- Sits between the request unit / datapath and RAM.
- Serialises one transaction at a time, stalls the losing requester with a wait signal, and returns read data.
- Data requests have priority. A starvation counter guarantees instruction forward progress. A watchdog aborts hung transactions.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits
MAX_DSTREAK, 4, max consecutive data grants while an instruction request waits (1..15)
TIMEOUT, 255, max cycles in a grant state without RAM ACCESS before abort (1..255)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
iREN  in  1  instruction read request (level, held until iwait low)
iaddr  in  ADDR_W  instruction address
dREN  in  1  data read request (level)
dWEN  in  1  data write request (level)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
iwait  out  1  instruction stall; low for exactly the completion cycle
dwait  out  1  data stall; low for exactly the completion cycle
iload  out  DATA_W  instruction read data, valid when iwait low
dload  out  DATA_W  data read data, valid when dwait low and dREN
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
merr  out  1  one-cycle pulse on ERROR or timeout abort

Behaviour:
- Single clock. All state updates on the CLK rising edge when nRST is high. nRST low at an edge forces reset regardless of state, including mid-transaction.
- Reset values:
  - state = IDLE; streak = 0; timer = 0; merr = 0.
  - iwait = 1, dwait = 1; ramREN = ramWEN = 0; ramaddr = 0, ramstore = 0.
  - iload and dload follow ramload; their value is don't-care while the corresponding wait is high.
- States:
  - IDLE: no RAM enables; both waits high.
  - IGNT: ramREN = 1; ramaddr = iaddr.
  - DGNT: ramaddr = daddr; ramstore = dstore; ramWEN = dWEN; ramREN = dREN & ~dWEN (write wins if both asserted).
- RAM-side signals are driven combinationally from the owner's live inputs while in a grant state. Requesters hold their inputs stable until their wait drops.
- Transitions from IDLE:
  - Go to DGNT if (dREN|dWEN) and not (iREN and streak == MAX_DSTREAK).
  - Otherwise go to IGNT if iREN.
  - Otherwise stay in IDLE.
- In a grant state, when ramstate == ACCESS:
  - Owner's wait goes low in that same cycle (combinational). Load data = ramload.
  - Next state = IDLE.
  - Minimum latency from request to wait low: 2 cycles (one arbitration cycle plus one access cycle). Back-to-back transactions therefore take 2 cycles each.
- Abort conditions (merr pulses the following cycle in each case):
  - ramstate == ERROR: next state IDLE, owner's wait stays high, merr = 1 next cycle.
  - Owner drops its request before ACCESS: next state IDLE, no completion, no merr. RAM enables drop in the same cycle as the request because they follow live inputs.
  - timer reaches TIMEOUT: next state IDLE, merr = 1 next cycle.
- timer: cleared on entering any grant state, +1 every cycle in a grant state without ACCESS, saturating.
- streak:
  - On D completion with iREN high: streak + 1, saturating at MAX_DSTREAK.
  - On I completion, or any cycle with iREN low: streak = 0.
- Simultaneous new iREN and dREN in IDLE: D wins unless streak == MAX_DSTREAK.
- A request arriving while the other owner is granted waits. It is re-arbitrated in IDLE on the cycle after completion.
- Invariants:
  - Never both ramREN and ramWEN.
  - Never both waits low in the same cycle.
  - No RAM enables in IDLE.

Test Plan:
- Reset: hold nRST low 2 cycles with iREN=1 -> iwait=dwait=1, ramREN=ramWEN=0. First cycle after release is IDLE; IGNT the next cycle.
- Instruction fetch: iREN=1, iaddr=0x40, ramstate ACCESS on the first grant cycle, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40; iwait low exactly 1 cycle with iload=0xDEADBEEF; 2-cycle latency.
- Simultaneous requests: iREN=1, dWEN=1, daddr=0x80, dstore=0x1234 -> D served first with ramWEN=1, ramstore=0x1234; I granted in the second IDLE arbitration afterward.
- Starvation: iREN held, dREN continuously reasserted, MAX_DSTREAK=4 -> exactly 4 D completions, then the I grant; streak=0 after the I completion.
- Error and timeout: ramstate=ERROR in DGNT -> dwait stays 1, merr pulses 1 cycle, state returns to IDLE. ramstate held BUSY with TIMEOUT=8 -> abort after 8 grant cycles, merr pulses.
- Mid-operation events: drop dREN during BUSY -> ramREN drops the same cycle, IDLE next, no merr. Assert nRST low in DGNT -> all outputs at reset values after the edge.
